// File: rtl/fp32_pkg.sv
// fp32_pkg: shared FP32 field widths, status bit indices, divider FSM states and rounding modes.
package fp32_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam int ST_NV = 4;
    localparam int ST_DZ = 3;
    localparam int ST_OF = 2;
    localparam int ST_UF = 1;
    localparam int ST_NX = 0;
    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;
    typedef enum logic [2:0] {RNE, RTZ, RDN, RUP, RMM} rnd_t;
endpackage

// File: rtl/fp32_round_pack.sv
// fp32_round_pack: rounds a 24-bit mantissa with guard/sticky and packs an FP32 word plus {NV,DZ,OF,UF,NX}.
module fp32_round_pack
    import fp32_pkg::*;
(
    input  logic              i_sign,
    input  logic signed [9:0] i_exp,
    input  logic [23:0]       i_mant,
    input  logic              i_guard,
    input  logic              i_sticky,
    input  logic [2:0]        i_rnd_mode,
    output logic [31:0]       o_out,
    output logic [4:0]        o_status
);
    logic              w_any;
    logic              w_inc;
    logic              w_max;
    logic [24:0]       w_sum;
    logic [23:0]       w_mant_r;
    logic signed [9:0] w_exp_r;

    // Unlisted codes (5-7) fall through to round-to-nearest-even.
    assign w_any = i_guard | i_sticky;
    assign w_inc = (i_rnd_mode == RTZ) ? 1'b0 :
                   (i_rnd_mode == RDN) ? (i_sign & w_any) :
                   (i_rnd_mode == RUP) ? (~i_sign & w_any) :
                   (i_rnd_mode == RMM) ? i_guard :
                   (i_guard & (i_sticky | i_mant[0]));
    assign w_max = (i_rnd_mode == RTZ) | ((i_rnd_mode == RDN) & ~i_sign) | ((i_rnd_mode == RUP) & i_sign);
    assign w_sum    = {1'b0, i_mant} + {24'd0, w_inc};
    assign w_mant_r = w_sum[24] ? w_sum[24:1] : w_sum[23:0];
    assign w_exp_r  = w_sum[24] ? i_exp + 10'sd1 : i_exp;

    assign o_out = (i_exp <= 10'sd0)     ? {i_sign, 31'd0} :
                   (w_exp_r >= 10'sd255) ? (w_max ? {i_sign, 31'h7F7FFFFF} : {i_sign, 8'hFF, 23'd0}) :
                   {i_sign, w_exp_r[7:0], w_mant_r[22:0]};
    assign o_status = (i_exp <= 10'sd0)     ? ((5'd1 << ST_UF) | (5'd1 << ST_NX)) :
                      (w_exp_r >= 10'sd255) ? ((5'd1 << ST_OF) | (5'd1 << ST_NX)) :
                      {4'd0, w_any};
endmodule

// File: rtl/fp_div_fp32_iter.sv
// fp_div_fp32_iter: iterative FP32 divider (restoring radix-2, FTZ/DAZ) with valid/ready on both sides.
// Optional macro FP_DIV_RND_MODE_EN adds a rnd_mode input sampled at accept; otherwise RNE only.
module fp_div_fp32_iter
    import fp32_pkg::*;
#(
    parameter logic [31:0] CANON_NAN      = 32'h7FC00000,
    parameter int          BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inA,
    input  logic [31:0] inB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic [4:0]  status
`ifdef FP_DIV_RND_MODE_EN
    ,
    input  logic [2:0]  rnd_mode
`endif
);
    localparam int ITERS = 26 / BITS_PER_CYCLE;

    state_t            r_state;
    logic [4:0]        r_cnt;
    logic [24:0]       r_rem;
    logic [25:0]       r_q;
    logic [23:0]       r_mb;
    logic              r_sign;
    logic signed [9:0] r_exp;
    logic [31:0]       r_out;
    logic [4:0]        r_status;
    logic [2:0]        w_rnd;
`ifdef FP_DIV_RND_MODE_EN
    logic [2:0]        r_rnd;
    assign w_rnd = r_rnd;
`else
    assign w_rnd = RNE;
`endif

    logic [7:0]  w_ea, w_eb;
    logic [22:0] w_fa, w_fb;
    logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic        w_nan_case, w_nv, w_special, w_sign;
    logic [31:0] w_sp_out;
    logic [4:0]  w_sp_st;
    logic signed [9:0] w_exp_d;

    assign w_ea       = inA[30:23];
    assign w_eb       = inB[30:23];
    assign w_fa       = inA[22:0];
    assign w_fb       = inB[22:0];
    assign w_sign     = inA[31] ^ inB[31];
    assign w_a_zero   = w_ea == 8'd0;
    assign w_b_zero   = w_eb == 8'd0;
    assign w_a_inf    = (w_ea == 8'hFF) & (w_fa == 23'd0);
    assign w_b_inf    = (w_eb == 8'hFF) & (w_fb == 23'd0);
    assign w_a_nan    = (w_ea == 8'hFF) & (w_fa != 23'd0);
    assign w_b_nan    = (w_eb == 8'hFF) & (w_fb != 23'd0);
    assign w_special  = w_a_zero | w_b_zero | (w_ea == 8'hFF) | (w_eb == 8'hFF);
    assign w_nan_case = w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf);
    assign w_nv       = (w_a_nan & ~w_fa[22]) | (w_b_nan & ~w_fb[22]) | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf);
    assign w_sp_out   = w_nan_case ? CANON_NAN :
                        (w_a_inf | w_b_zero) ? {w_sign, 8'hFF, 23'd0} : {w_sign, 31'd0};
    assign w_sp_st    = w_nan_case ? (w_nv ? 5'(1 << ST_NV) : 5'd0) :
                        (w_b_zero & ~w_a_inf) ? 5'(1 << ST_DZ) : 5'd0;
    // Exponent assumes q[25]=0; the round stage adds one when the quotient lands in [2^25, 2^26).
    assign w_exp_d    = 10'(w_ea) - 10'(w_eb) + 10'sd126;

    logic [24:0] w_rem_n;
    logic [25:0] w_q_n;
    always_comb begin
        w_rem_n = r_rem;
        w_q_n   = r_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            w_q_n   = {w_q_n[24:0], w_rem_n >= {1'b0, r_mb}};
            w_rem_n = w_q_n[0] ? w_rem_n - {1'b0, r_mb} : w_rem_n;
            w_rem_n = w_rem_n << 1;
        end
    end

    logic [31:0] w_rp_out;
    logic [4:0]  w_rp_st;
    fp32_round_pack u_rp (
        .i_sign     (r_sign),
        .i_exp      (r_q[25] ? r_exp + 10'sd1 : r_exp),
        .i_mant     (r_q[25] ? r_q[25:2] : r_q[24:1]),
        .i_guard    (r_q[25] ? r_q[1] : r_q[0]),
        .i_sticky   ((r_q[25] & r_q[0]) | (r_rem != 25'd0)),
        .i_rnd_mode (w_rnd),
        .o_out      (w_rp_out),
        .o_status   (w_rp_st)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_out    <= 32'd0;
            r_status <= 5'd0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_sign  <= w_sign;
                    r_exp   <= w_exp_d;
                    r_rem   <= {2'b01, w_fa};
                    r_mb    <= {1'b1, w_fb};
                    r_cnt   <= 5'(ITERS - 1);
`ifdef FP_DIV_RND_MODE_EN
                    r_rnd   <= rnd_mode;
`endif
                    r_state <= w_special ? DONE : DIV;
                    if (w_special) begin
                        r_out    <= w_sp_out;
                        r_status <= w_sp_st;
                    end
                end
                DIV: begin
                    r_rem <= w_rem_n;
                    r_q   <= w_q_n;
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd0) r_state <= ROUND;
                end
                ROUND: begin
                    r_out    <= w_rp_out;
                    r_status <= w_rp_st;
                    r_state  <= DONE;
                end
                DONE: if (out_ready) r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign out       = r_out;
    assign status    = r_status;
endmodule

// File: tb/tb_fp_div_fp32_iter.sv
// tb_fp_div_fp32_iter: directed and random checks of fp_div_fp32_iter against an integer-arithmetic reference.
module tb_fp_div_fp32_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] inA = 32'd0;
    logic [31:0] inB = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out;
    logic [4:0]  status;
    int          n_chk = 0;
    int          n_fail = 0;

    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [4:0] NV = 5'b10000, DZ = 5'b01000, OF = 5'b00100, UF = 5'b00010, NX = 5'b00001;

    fp_div_fp32_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inA       (inA),
        .inB       (inB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .status    (status)
`ifdef FP_DIV_RND_MODE_EN
        ,
        .rnd_mode  (3'd0)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer quotient of the 24-bit significands, then RNE and range rules.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] o, output logic [4:0] st, output bit sp);
        bit s = a[31] ^ b[31];
        int ea = int'(a[30:23]), eb = int'(b[30:23]);
        bit an = (ea == 255) && (a[22:0] != 0), bn = (eb == 255) && (b[22:0] != 0);
        bit ai = (ea == 255) && (a[22:0] == 0), bi = (eb == 255) && (b[22:0] == 0);
        bit az = (ea == 0), bz = (eb == 0);
        longint ma, mb, q, rem, mant;
        int e;
        bit g, stk;
        sp = an || bn || ai || bi || az || bz;
        st = 5'd0;
        if (an || bn) begin
            o = QNAN;
            st = ((an && !a[22]) || (bn && !b[22])) ? NV : 5'd0;
        end else if ((az && bz) || (ai && bi)) begin
            o = QNAN; st = NV;
        end else if (ai) begin
            o = {s, 8'hFF, 23'd0};
        end else if (bz) begin
            o = {s, 8'hFF, 23'd0}; st = DZ;
        end else if (bi || az) begin
            o = {s, 31'd0};
        end else begin
            ma = longint'({1'b1, a[22:0]});
            mb = longint'({1'b1, b[22:0]});
            q = (ma * (64'd1 << 25)) / mb;
            rem = (ma * (64'd1 << 25)) % mb;
            if (q >= (64'd1 << 25)) begin
                mant = q / 4; g = q[1]; stk = q[0] || (rem != 0); e = ea - eb + 127;
            end else begin
                mant = q / 2; g = q[0]; stk = (rem != 0); e = ea - eb + 126;
            end
            if (e <= 0) begin
                o = {s, 31'd0}; st = UF | NX;
            end else begin
                if (g && (stk || mant[0])) mant++;
                if (mant == (64'd1 << 24)) begin mant = mant / 2; e++; end
                if (e >= 255) begin
                    o = {s, 8'hFF, 23'd0}; st = OF | NX;
                end else begin
                    o = {s, e[7:0], mant[22:0]}; st = (g || stk) ? NX : 5'd0;
                end
            end
        end
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] eo;
        logic [4:0]  es;
        bit          sp;
        int          n;
        model(a, b, eo, es, sp);
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; inA = a; inB = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".latency"}, 32'(n), sp ? 32'd1 : 32'd28);
        chk({tag, ".out"}, out, eo);
        chk({tag, ".status"}, 32'(status), 32'(es));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_out"}, out, eo);
            chk({tag, ".hold_status"}, 32'(status), 32'(es));
            chk({tag, ".hold_ready"}, {31'd0, in_ready, out_valid}, 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (hold > 0) chk({tag, ".release"}, {31'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        int seen;
        logic [31:0] a, b;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.out", out, 32'd0);
        chk("reset.status", 32'(status), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("six_div_two", 32'h40C00000, 32'h40000000, 0);
        chk("six_div_two.value", out, 32'h40400000);
        run("one_div_three", 32'h3F800000, 32'h40400000, 0);
        chk("one_div_three.value", out, 32'h3EAAAAAB);
        run("one_div_zero", 32'h3F800000, 32'h00000000, 0);
        chk("one_div_zero.status", 32'(status), 32'(DZ));
        run("zero_div_zero", 32'h00000000, 32'h80000000, 0);
        chk("zero_div_zero.value", out, QNAN);
        run("overflow", 32'h7F7FFFFF, 32'h3F000000, 0);
        chk("overflow.status", 32'(status), 32'(OF | NX));
        run("underflow", 32'h00800000, 32'h40000000, 0);
        chk("underflow.status", 32'(status), 32'(UF | NX));
        run("snan", 32'h7F800001, 32'h3F800000, 0);
        run("qnan", 32'h3F800000, 32'hFFC00010, 0);
        run("inf_inf", 32'hFF800000, 32'h7F800000, 0);
        run("inf_fin", 32'hFF800000, 32'h40000000, 0);
        run("fin_inf", 32'h40000000, 32'hFF800000, 0);
        run("zero_fin", 32'h80000000, 32'h40000000, 0);
        run("denorm_div", 32'h00400000, 32'h3F800000, 0);
        run("backpressure", 32'h3F800000, 32'h40400000, 5);
        run("after_bp", 32'hC0C00000, 32'h40000000, 0);

        @(negedge clk);
        in_valid = 1'b1; inA = 32'h40C00000; inB = 32'h40000000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midreset.idle", {31'd0, in_ready, out_valid}, 32'd2);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("midreset.no_stale", 32'(seen), 32'd0);
        run("after_reset", 32'h3F800000, 32'h40400000, 0);

        for (int k = 0; k < 150; k++) begin
            a = $urandom;
            b = $urandom;
            if (k % 3 != 0) begin
                a[30:23] = 8'($urandom_range(40, 215));
                b[30:23] = 8'($urandom_range(40, 215));
            end
            run($sformatf("rand%0d", k), a, b, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_div_fp32_iter.md
Name: fp_div_fp32_iter

Overview:
- Iterative IEEE-754 single-precision divider: out = inA / inB.
- Multi-cycle, one operation in flight, full valid/ready handshake on both sides.
- Companion to the team's single-cycle FP32 multiply wrapper. Sits in the same datapath slot, but actually drives its handshake instead of tying it off.
- Restoring radix-2 mantissa division, then a round/pack stage.

Parameters:
- CANON_NAN, 32'h7FC00000, value emitted for every NaN result.
- BITS_PER_CYCLE, 1, quotient bits retired per DIV cycle. Legal values are 1 or 2.
- ITERS, derived = 26/BITS_PER_CYCLE. Localparam, not overridable.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- inA  in  32  dividend, FP32.
- inB  in  32  divisor, FP32.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out  out  32  quotient, FP32.
- status  out  5  {NV,DZ,OF,UF,NX}, valid with out_valid.

Behaviour:
- Reset values: state IDLE, in_ready=1, out_valid=0, out=0, status=0. Reset mid-operation abandons the operation; no output is produced for it.
- FSM states:
  - IDLE: in_ready=1. On in_valid: capture operands. Specials go to DONE; others go to DIV.
  - DIV: ITERS cycles.
  - ROUND: 1 cycle.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- in_ready is 0 in DIV, ROUND and DONE. There is no overlap of accept with a pending result.
- Latency, counted from the accept edge to the edge that first sets out_valid:
  - normal operands: ITERS+2 edges (28 at default);
  - special operands: 1 edge.
- DONE holds out and status stable while out_ready=0.
- Operand handling: FTZ/DAZ. Subnormal inputs are treated as zero; results below the normal range flush to signed zero with UF|NX.
- Sign of every result = sA^sB. NaN results are the exception and use CANON_NAN.
- Special cases:
  - any NaN input gives CANON_NAN. NV is set only if an input is sNaN.
  - 0/0 and inf/inf give CANON_NAN with NV.
  - finite nonzero / 0 gives inf with DZ.
  - inf/finite gives inf, flags 0.
  - finite/inf gives 0, flags 0.
  - 0/nonzero-finite gives 0, flags 0.
- Division datapath:
  - ma={1,fracA}, mb={1,fracB}, 24 bits each.
  - q = floor(ma·2^25/mb), 26 bits, in [2^24, 2^26). rem = remainder.
  - If q[25]=1: mant=q[25:2], guard=q[1], sticky=q[0]|(rem!=0), exp=eA-eB+127.
  - If q[25]=0: mant=q[24:1], guard=q[0], sticky=(rem!=0), exp=eA-eB+126.
  - Exponent arithmetic is signed, 10 bits.
- Rounding: RNE. Increment if guard & (sticky | mant[0]). Mantissa carry-out shifts the mantissa and does exp+1. NX = guard|sticky.
- Range:
  - exp≥255 after rounding gives inf with OF|NX.
  - exp≤0 gives signed zero with UF|NX.

Optional Feature:
- Macro FP_DIV_RND_MODE_EN.
- Defined: adds input port rnd_mode (3 bits, RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4), sampled at accept.
  - Overflow under RTZ, or under the directed mode away from the result's sign, returns the max finite value 0x7F7FFFFF (sign applied) instead of inf.
  - Codes 5-7 behave as RNE.
- Undefined: no port; RNE only.

Decomposition:
- Package fp32_pkg holds:
  - field widths (EXP_W=8, MAN_W=23), BIAS=127;
  - the status bit-index constants;
  - the FSM state enum {IDLE,DIV,ROUND,DONE};
  - the rounding-mode enum.
- Sub-module fp32_round_pack: combinational. Takes sign, signed exp, 24-bit mant, guard, sticky, (rnd_mode) and returns {out, status}. Also reusable by other FP32 blocks.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2) -> out 0x40400000, status 0, out_valid exactly 28 edges after accept.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB, status NX.
- 0x3F800000 / 0x00000000 -> 0x7F800000, DZ, latency 1. 0/0 -> 0x7FC00000, NV.
- 0x7F7FFFFF / 0x3F000000 -> 0x7F800000, OF|NX. 0x00800000 / 0x40000000 -> 0x00000000, UF|NX.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out and status stable, in_ready=0. Then out_ready=1 -> IDLE, and the next accept works.
- Assert rst in DIV cycle 10 -> next cycle IDLE, in_ready=1, out_valid=0, and no stale result ever appears.
